// File: rtl/imem_refill_arbiter_pkg.sv
// imem_refill_arbiter_pkg: shared state encoding, line geometry and port indices for the refill arbiter
package imem_refill_arbiter_pkg;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int LINE_WORDS = 4;
    localparam int LINE_WIDTH = INSTRUCTION_WIDTH * LINE_WORDS;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        ABORT = 3'd4
    } state_t;
endpackage

// File: rtl/imem_refill_arbiter_if.sv
// imem_refill_arbiter_if: refill request ports and the block-read memory bus seen by the arbiter
interface imem_refill_arbiter_if #(parameter int BLOCK_ADDR_WIDTH = 28);
    import imem_refill_arbiter_pkg::*;
    logic req0;
    logic [BLOCK_ADDR_WIDTH-1:0] req_addr0;
    logic req1;
    logic [BLOCK_ADDR_WIDTH-1:0] req_addr1;
    logic grant0;
    logic grant1;
    logic done0;
    logic done1;
    logic err0;
    logic err1;
    logic [LINE_WIDTH-1:0] resp_data;
    logic mem_read;
    logic [BLOCK_ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_readdata;
    logic mem_busywait;
    modport master (
        input  req0, req_addr0, req1, req_addr1, mem_readdata, mem_busywait,
        output grant0, grant1, done0, done1, err0, err1, resp_data, mem_read, mem_address
    );
    modport slave (
        output req0, req_addr0, req1, req_addr1, mem_readdata, mem_busywait,
        input  grant0, grant1, done0, done1, err0, err1, resp_data, mem_read, mem_address
    );
endinterface

// File: rtl/imem_refill_arbiter_rr.sv
// rr_arbiter2: two-way round-robin pick; on a tie the port that did not win last goes
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic pick
);
    assign valid = req0 | req1;
    assign pick = (req0 & req1) ? ~last_grant : req1;
endmodule

// File: rtl/imem_refill_arbiter.sv
// imem_refill_arbiter: shares one block-read instruction memory between two cache miss ports
module imem_refill_arbiter
    import imem_refill_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_ADDR_WIDTH = ADDRESS_WIDTH - 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic clock,
    input logic reset,
    imem_refill_arbiter_if.master bus
);
    state_t state;
    logic owner;
    logic last_grant;
    logic [BLOCK_ADDR_WIDTH-1:0] addr_q;
    logic [7:0] count;
    logic [LINE_WIDTH-1:0] data_q;
    logic arb_valid;
    logic arb_pick;
    logic other_req;
    logic [BLOCK_ADDR_WIDTH-1:0] other_addr;
    logic merge;
    logic active;
    logic reading;

    rr_arbiter2 u_rr (
        .req0(bus.req0),
        .req1(bus.req1),
        .last_grant(last_grant),
        .valid(arb_valid),
        .pick(arb_pick)
    );

    assign other_req = owner ? bus.req0 : bus.req1;
    assign other_addr = owner ? bus.req_addr0 : bus.req_addr1;
    // A waiting requester for the same line is satisfied by the line just fetched
    assign merge = (state == RESP) && other_req && (other_addr == addr_q);
    assign active = state != IDLE;
    assign reading = (state == ISSUE) || (state == WAIT);

    assign bus.grant0 = active && (owner == PORT0);
    assign bus.grant1 = active && (owner == PORT1);
    assign bus.done0 = (state == RESP) && ((owner == PORT0) || merge);
    assign bus.done1 = (state == RESP) && ((owner == PORT1) || merge);
    assign bus.err0 = (state == ABORT) && (owner == PORT0);
    assign bus.err1 = (state == ABORT) && (owner == PORT1);
    assign bus.mem_read = reading;
    assign bus.mem_address = reading ? addr_q : '0;
    assign bus.resp_data = data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= PORT0;
            last_grant <= PORT1;
            addr_q <= '0;
            count <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: if (arb_valid) begin
                    owner <= arb_pick;
                    last_grant <= arb_pick;
                    addr_q <= arb_pick ? bus.req_addr1 : bus.req_addr0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    count <= '0;
                    state <= WAIT;
                end
                WAIT: if (!bus.mem_busywait) begin
                    data_q <= bus.mem_readdata;
                    state <= RESP;
                end else if (count == 8'(TIMEOUT_CYCLES - 1)) begin
                    state <= ABORT;
                end else begin
                    count <= count + 8'd1;
                end
                // Hand the memory straight to a distinct waiting request, skipping IDLE
                RESP: if (other_req && !merge) begin
                    owner <= ~owner;
                    last_grant <= ~owner;
                    addr_q <= other_addr;
                    state <= ISSUE;
                end else begin
                    state <= IDLE;
                end
                ABORT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_refill_arbiter.sv
// tb_imem_refill_arbiter: directed scoreboard bench for the two-port refill arbiter
module tb_imem_refill_arbiter;
    import imem_refill_arbiter_pkg::*;

    typedef struct {
        logic port;
        logic err;
        logic [LINE_WIDTH-1:0] data;
    } exp_t;

    logic clock;
    logic reset;
    imem_refill_arbiter_if #(.BLOCK_ADDR_WIDTH(28)) bus ();

    imem_refill_arbiter #(
        .ADDRESS_WIDTH(32),
        .BLOCK_ADDR_WIDTH(28),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int lat = 4;
    int rd_cnt = 0;
    int rd_total = 0;
    int rd_starts = 0;
    logic [1:0] last_done = '0;
    logic both_done = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [LINE_WIDTH-1:0] line_of(logic [27:0] a);
        logic [31:0] w;
        w = {4'h0, a};
        return {32'h4444_0000 ^ w, 32'h3333_0000 ^ w, 32'h2222_0000 ^ w, 32'h1111_0000 ^ w};
    endfunction

    task automatic check(string tag, logic [LINE_WIDTH-1:0] obs, logic [LINE_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(logic port, logic err, logic [27:0] addr);
        exp_t e;
        e.port = port;
        e.err = err;
        e.data = line_of(addr);
        q.push_back(e);
    endtask

    task automatic take_event(logic port, logic err);
        exp_t e;
        if (q.size() == 0) begin
            check("unexpected_event", {port, err}, 2'b11 ^ {port, err});
        end else begin
            e = q.pop_front();
            check("event_port", port, e.port);
            check("event_kind", err, e.err);
            if (!err) check("event_data", bus.resp_data, e.data);
        end
        if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    endtask

    // Runs at each negedge: invariants, scoreboard, requester drop and memory model
    task automatic monitor();
        check("grant_onehot", bus.grant0 & bus.grant1, 1'b0);
        check("addr_zero_idle", bus.mem_read ? '0 : bus.mem_address, '0);
        last_done = {bus.done1, bus.done0};
        both_done = both_done | (bus.done0 & bus.done1);
        if (bus.done0 || bus.err0) take_event(1'b0, bus.err0);
        if (bus.done1 || bus.err1) take_event(1'b1, bus.err1);
        if (bus.mem_read) begin
            rd_cnt++;
            rd_total++;
            if (rd_cnt == 1) rd_starts++;
        end else begin
            rd_cnt = 0;
        end
        bus.mem_busywait = !(bus.mem_read && rd_cnt >= lat);
        bus.mem_readdata = line_of(bus.mem_address);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        monitor();
    endtask

    task automatic drain(output int n);
        n = 0;
        while (q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_in_budget", q.size() == 0, 1'b1);
    endtask

    int n;
    int starts0;
    int rem0;
    int rem1;

    initial begin
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.req_addr0 = '0;
        bus.req_addr1 = '0;
        bus.mem_busywait = 1'b1;
        bus.mem_readdata = '0;
        @(negedge clock);
        @(negedge clock);
        check("rst_grant", {bus.grant1, bus.grant0}, 2'b00);
        check("rst_pulses", {bus.done1, bus.done0, bus.err1, bus.err0}, 4'b0);
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_addr", bus.mem_address, '0);
        check("rst_resp_data", bus.resp_data, '0);
        reset = 1'b0;
        step();

        // Single request, three busy cycles
        rd_total = 0;
        lat = 4;
        bus.req_addr0 = 28'h10;
        bus.req0 = 1'b1;
        expect_ev(1'b0, 1'b0, 28'h10);
        step();
        check("single_grant0", {bus.grant1, bus.grant0}, 2'b01);
        check("single_issue_addr", bus.mem_address, 28'h10);
        drain(n);
        check("single_latency", n + 1, 5);
        check("single_read_cycles", rd_total, 4);
        check("single_read_low", bus.mem_read, 1'b0);
        step();
        step();
        check("single_resp_hold", bus.resp_data, line_of(28'h10));

        // Simultaneous requests after reset: port 0 first, port 1 issued without IDLE
        reset = 1'b1;
        step();
        reset = 1'b0;
        lat = 2;
        bus.req_addr0 = 28'h10;
        bus.req_addr1 = 28'h20;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        expect_ev(1'b0, 1'b0, 28'h10);
        expect_ev(1'b1, 1'b0, 28'h20);
        n = 0;
        last_done = '0;
        while (!last_done[0] && n < 50) begin
            step();
            n++;
        end
        check("tie_done0_seen", last_done[0], 1'b1);
        step();
        check("tie_back_to_back_read", bus.mem_read, 1'b1);
        check("tie_back_to_back_addr", bus.mem_address, 28'h20);
        check("tie_grant1", {bus.grant1, bus.grant0}, 2'b10);
        drain(n);

        // Continuous contention: 0,1,0,1
        lat = 3;
        step();
        bus.req_addr0 = 28'h100;
        bus.req_addr1 = 28'h200;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        expect_ev(1'b0, 1'b0, 28'h100);
        expect_ev(1'b1, 1'b0, 28'h200);
        expect_ev(1'b0, 1'b0, 28'h300);
        expect_ev(1'b1, 1'b0, 28'h400);
        rem0 = 1;
        rem1 = 1;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            step();
            n++;
            if (last_done[0] && rem0 > 0) begin
                rem0--;
                bus.req_addr0 = 28'h300;
                bus.req0 = 1'b1;
            end
            if (last_done[1] && rem1 > 0) begin
                rem1--;
                bus.req_addr1 = 28'h400;
                bus.req1 = 1'b1;
            end
        end
        check("rr_all_served", q.size(), 0);

        // Merge of identical lines
        step();
        lat = 2;
        starts0 = rd_starts;
        both_done = 1'b0;
        bus.req_addr0 = 28'h40;
        bus.req_addr1 = 28'h40;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        expect_ev(1'b0, 1'b0, 28'h40);
        expect_ev(1'b1, 1'b0, 28'h40);
        drain(n);
        step();
        step();
        check("merge_one_read", rd_starts - starts0, 1);
        check("merge_same_cycle", both_done, 1'b1);

        // Timeout with memory stuck busy
        lat = 255;
        rd_total = 0;
        bus.req_addr1 = 28'h80;
        bus.req1 = 1'b1;
        expect_ev(1'b1, 1'b1, 28'h80);
        drain(n);
        check("timeout_latency", n, 10);
        check("timeout_read_cycles", rd_total, 9);
        check("timeout_read_low", bus.mem_read, 1'b0);
        check("timeout_resp_kept", bus.resp_data, line_of(28'h40));
        lat = 2;
        bus.req_addr0 = 28'h90;
        bus.req0 = 1'b1;
        expect_ev(1'b0, 1'b0, 28'h90);
        drain(n);
        check("after_timeout_data", bus.resp_data, line_of(28'h90));

        // Asynchronous reset in the middle of WAIT
        step();
        lat = 255;
        bus.req_addr0 = 28'h10;
        bus.req_addr1 = 28'h20;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step();
        step();
        step();
        check("pre_reset_reading", bus.mem_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_mem_read", bus.mem_read, 1'b0);
        check("async_grants", {bus.grant1, bus.grant0}, 2'b00);
        check("async_resp_data", bus.resp_data, '0);
        step();
        step();
        reset = 1'b0;
        lat = 2;
        expect_ev(1'b0, 1'b0, 28'h10);
        expect_ev(1'b1, 1'b0, 28'h20);
        step();
        check("post_reset_grant0", {bus.grant1, bus.grant0}, 2'b01);
        drain(n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
